instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-issue CPU. Owns the program counter, drives a synchronous-read instruction ROM, and hands each fetched 9-bit instruction (`Opcode`/`Funct`/`Operand` fields plus a valid flag) to the `Control` decoder. It consumes the decoder's `Branch`, `BranchCond` and `Halt` outputs to redirect or stop fetch. It also implements the program start/done handshake with the testbench or host.

## Interface
- `PC_W`, default 10: program counter and ROM address width.
- `CNT_W`, default 16: cycle counter width.

- `CLK`  in  1: clock; all state updates on the rising edge.
- `Reset_n`  in  1: synchronous, active-low reset.
- `Start`  in  1: level-sampled; begins execution at `StartAddr` when the FSM is in IDLE or HALTED.
- `StartAddr`  in  PC_W: first instruction address.
- `InstAddr`  out  PC_W: ROM read address; equals the PC register.
- `InstData`  in  9: ROM registered output, `mem[InstAddr]` from the previous cycle.
- `Instruction`  out  9: equals `InstData`.
- `Opcode`  out  3: bits [8:6].
- `Funct`  out  3: bits [5:3].
- `Operand`  out  3: bits [2:0].
- `InstValid`  out  1: the current instruction is real. The datapath gates `RegWrite`, `MemWrite` and `OvWrite` with this signal.
- `Branch`, `BranchCond`, `Halt`  in  1 each: from `Control` for the current instruction.
- `Zero`  in  1: condition flag for `bez`.
- `BranchTarget`  in  PC_W: absolute target from the register file.
- `Done`  out  1: program has halted.
- `CycleCount`  out  CNT_W: number of RUN cycles since the last start.

## Operation
- FSM states:
  - IDLE: reset state. On `Start`, load PC with `StartAddr`, clear `Pending` and `CycleCount`, then go to RUN.
  - RUN: each cycle, `InstAddr` = PC, and next PC = PC+1 modulo 2^PC_W (wraps from all-ones to 0). `Pending` is set to 1, meaning an address was issued and not squashed.
  - HALTED: `Done` = 1. PC and `CycleCount` are frozen. `Start` behaves exactly as it does in IDLE (restart).
- `InstValid` = `Pending` AND (state == RUN).
- Redirect rules are evaluated only when `InstValid` = 1. `Branch`, `Halt` and `Zero` are ignored while `InstValid` = 0.
- Branch is taken when `Branch` AND (NOT `BranchCond` OR `Zero`). On a taken branch:
  - PC <= `BranchTarget`.
  - `Pending` <= 0, squashing the sequential fetch issued this cycle.
- Halt: state <= HALTED, `Pending` <= 0. Halt has priority over a simultaneous taken branch, and PC is not updated.
- `Start` while in RUN is ignored.
- `CycleCount` increments in every RUN cycle and saturates at all-ones (no wrap).
- Reset values, including a reset mid-run (reset overrides every other event in the same cycle):
  - state IDLE, PC 0, `Pending` 0.
  - `InstValid` 0, `Done` 0, `CycleCount` 0.

## Timing
- Start latency: with `Start` sampled at edge 0, `InstAddr` = `StartAddr` in cycle 1, and the first `InstValid` = 1 is in cycle 2.
- Throughput: one instruction per cycle when there is no redirect.
- Taken branch at cycle k:
  - Cycle k+1: `InstAddr` = target, `InstValid` = 0 (one bubble).
  - Cycle k+2: the target instruction is valid.
- Untaken conditional branch: no bubble.
- Halt at cycle k: `Done` = 1 and `InstValid` = 0 from cycle k+1 onward.
- Decoder inputs are combinational within the cycle. There is no combinational path from `Branch`/`Halt` to `InstAddr`; redirects take effect via the PC register.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum {IDLE, RUN, HALTED}.
  - `INSTR_W` = 9.
  - Field position constants `OPC_MSB`/`OPC_LSB`, `FN_MSB`/`FN_LSB`.
  - Opcode constants `OP_LI`, `OP_GRP1`, `OP_GRP2`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_SLT`.
  - Funct constants `FN_HALT` = 3'b101, `FN_BR` = 3'b000, `FN_BEZ` = 3'b001.
- Sub-module `pc_unit`: PC register plus next-PC mux (hold / +1 / target / StartAddr), with the select driven by the top-level FSM.

## Test plan
- Reset, then `Start` with `StartAddr` = 5, and the ROM holding `add` at addresses 5..7 -> `InstAddr` = 5, 6, 7 in cycles 1..3; `InstValid` rises in cycle 2; `Opcode` = 3'b011.
- `br` (`Opcode` 010, `Funct` 000) at address 7 with `BranchTarget` = 20 -> exactly one `InstValid` = 0 cycle, then the instruction at address 20 is valid; the instruction at address 8 never becomes valid.
- `bez` with `Zero` = 0 -> no bubble, address 8 follows 7. With `Zero` = 1 -> redirect to target.
- `halt` (001/101) with `Branch` also asserted -> `Done` = 1 next cycle, PC frozen, `CycleCount` frozen. A later `Start` with `StartAddr` = 0 restarts with `Done` = 0 and `CycleCount` = 0.
- PC wrap: `StartAddr` = 1023 with `PC_W` = 10 -> next `InstAddr` = 0. `Reset_n` low mid-RUN -> all outputs at reset values the next cycle.
- Run to force `CycleCount` to 16'hFFFF (reduce `CNT_W` to 4 for the bench) -> the count holds at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction field layout,
// opcode/funct constants and the PC next-value select codes used between
// instr_fetch and pc_unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int INSTR_W = 9;

  // Instruction fields: [8:6] opcode, [5:3] funct, [2:0] operand
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 3;

  localparam logic [2:0] OP_LI   = 3'b000;
  localparam logic [2:0] OP_GRP1 = 3'b001;
  localparam logic [2:0] OP_GRP2 = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [2:0] FN_HALT = 3'b101;
  localparam logic [2:0] FN_BR   = 3'b000;
  localparam logic [2:0] FN_BEZ  = 3'b001;

  // Next-PC select
  localparam logic [1:0] PC_HOLD  = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_TGT   = 2'd2;
  localparam logic [1:0] PC_START = 2'd3;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: host start/done, ROM address/data, decoded instruction
// fields and the decoder feedback (branch/halt) consumed by fetch.
//   master : instr_fetch side
//   slave  : host / ROM / decoder side
interface instr_fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic                        Start;
  logic [PC_W-1:0]             StartAddr;
  logic [PC_W-1:0]             InstAddr;
  logic [cpu_pkg::INSTR_W-1:0] InstData;
  logic [cpu_pkg::INSTR_W-1:0] Instruction;
  logic [2:0]                  Opcode;
  logic [2:0]                  Funct;
  logic [2:0]                  Operand;
  logic                        InstValid;
  logic                        Branch;
  logic                        BranchCond;
  logic                        Halt;
  logic                        Zero;
  logic [PC_W-1:0]             BranchTarget;
  logic                        Done;
  logic [CNT_W-1:0]            CycleCount;

  modport master (
    input  Start, StartAddr, InstData, Branch, BranchCond, Halt, Zero, BranchTarget,
    output InstAddr, Instruction, Opcode, Funct, Operand, InstValid, Done, CycleCount
  );

  modport slave (
    output Start, StartAddr, InstData, Branch, BranchCond, Halt, Zero, BranchTarget,
    input  InstAddr, Instruction, Opcode, Funct, Operand, InstValid, Done, CycleCount
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter register and next-PC mux.
//   i_clk, i_rst_n : clock, synchronous active-low reset (PC -> 0)
//   i_sel          : PC_HOLD / PC_INC / PC_TGT / PC_START
//   i_start_addr   : load value for PC_START
//   i_target       : load value for PC_TGT
//   o_pc           : current PC (drives the ROM address directly)
module pc_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_sel,
  input  logic [PC_W-1:0] i_start_addr,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    case (i_sel)
      PC_INC:   w_pc_nxt = r_pc + PC_W'(1);  // wraps naturally at all-ones
      PC_TGT:   w_pc_nxt = i_target;
      PC_START: w_pc_nxt = i_start_addr;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_pc <= '0;
    else          r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC (via pc_unit), issues ROM addresses,
// presents the fetched instruction and its fields with a valid flag, and
// redirects/stops fetch on decoder Branch/Halt. Start/Done host handshake
// plus a saturating RUN-cycle counter.
//   CLK, Reset_n : clock, synchronous active-low reset
//   fif          : instr_fetch_if master modport (host, ROM, decoder signals)
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic           CLK,
  input logic           Reset_n,
  instr_fetch_if.master fif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_HALTED = HALTED;

  logic [1:0]       r_state;
  logic             r_pend;   // address issued last cycle and not squashed
  logic [CNT_W-1:0] r_cnt;

  logic             w_vld;
  logic             w_halt;
  logic             w_take;
  logic             w_start;
  logic [1:0]       w_sel;
  logic [PC_W-1:0]  w_pc;

  assign w_vld   = r_pend && (r_state == ST_RUN);
  // Decoder inputs only matter for a real instruction; halt wins over branch.
  assign w_halt  = w_vld && fif.Halt;
  assign w_take  = w_vld && !fif.Halt && fif.Branch && (!fif.BranchCond || fif.Zero);
  assign w_start = fif.Start && (r_state == ST_IDLE || r_state == ST_HALTED);

  always_comb begin
    w_sel = PC_HOLD;
    if (w_start)                 w_sel = PC_START;
    else if (r_state == ST_RUN) begin
      if (w_halt)                w_sel = PC_HOLD;
      else if (w_take)           w_sel = PC_TGT;
      else                       w_sel = PC_INC;
    end
  end

  pc_unit #(.PC_W(PC_W)) u_pc (
    .i_clk        (CLK),
    .i_rst_n      (Reset_n),
    .i_sel        (w_sel),
    .i_start_addr (fif.StartAddr),
    .i_target     (fif.BranchTarget),
    .o_pc         (w_pc)
  );

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
          if (w_halt) begin
            r_state <= ST_HALTED;
            r_pend  <= 1'b0;
          end else begin
            // A taken branch squashes the sequential fetch issued this cycle.
            r_pend  <= !w_take;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign fif.InstAddr    = w_pc;
  assign fif.Instruction = fif.InstData;
  assign fif.Opcode      = fif.InstData[OPC_MSB:OPC_LSB];
  assign fif.Funct       = fif.InstData[FN_MSB:FN_LSB];
  assign fif.Operand     = fif.InstData[2:0];
  assign fif.InstValid   = w_vld;
  assign fif.Done        = (r_state == ST_HALTED);
  assign fif.CycleCount  = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  localparam logic [8:0] I_ADD  = {OP_ADD,  3'b000, 3'b000};
  localparam logic [8:0] I_SUB  = {OP_SUB,  3'b000, 3'b000};
  localparam logic [8:0] I_BR   = {OP_GRP2, FN_BR,  3'b000};
  localparam logic [8:0] I_BEZ  = {OP_GRP2, FN_BEZ, 3'b000};
  localparam logic [8:0] I_HALT = {OP_GRP1, FN_HALT, 3'b000};

  logic clk = 1'b0;
  logic rst_n;
  logic force_br;
  logic [8:0] mem [0:(1<<PC_W)-1];
  int n_chk = 0;
  int n_pass = 0;

  instr_fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) fif ();

  instr_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .fif     (fif)
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM
  always @(posedge clk) fif.InstData <= mem[fif.InstAddr];

  // Minimal decoder; force_br lets a halt arrive with Branch also set.
  always_comb begin
    fif.Halt       = (fif.Opcode == OP_GRP1) && (fif.Funct == FN_HALT);
    fif.Branch     = ((fif.Opcode == OP_GRP2) &&
                      (fif.Funct == FN_BR || fif.Funct == FN_BEZ)) || force_br;
    fif.BranchCond = (fif.Funct == FN_BEZ);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; force_br = 1'b0;
    fif.Start = 1'b0; fif.StartAddr = '0; fif.Zero = 1'b0; fif.BranchTarget = '0;
    fif.InstData = '0;
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = '0;
    mem[5] = I_ADD; mem[6] = I_ADD; mem[7] = I_BR; mem[8] = I_BR;
    mem[20] = I_SUB; mem[21] = I_BEZ; mem[22] = I_BEZ;
    mem[40] = I_ADD; mem[41] = I_HALT;

    repeat (2) cyc();
    chk("rst_addr", 32'(fif.InstAddr), 0);
    chk("rst_vld",  32'(fif.InstValid), 0);
    chk("rst_done", 32'(fif.Done), 0);
    chk("rst_cnt",  32'(fif.CycleCount), 0);

    rst_n = 1'b1;
    cyc();
    chk("idle_vld",  32'(fif.InstValid), 0);
    chk("idle_addr", 32'(fif.InstAddr), 0);

    // Start at 5
    fif.StartAddr = 10'd5; fif.Start = 1'b1;
    cyc();                                  // cycle 1
    fif.Start = 1'b0; fif.BranchTarget = 10'd20;
    chk("c1_addr", 32'(fif.InstAddr), 5);
    chk("c1_vld",  32'(fif.InstValid), 0);
    cyc();                                  // cycle 2
    chk("c2_addr", 32'(fif.InstAddr), 6);
    chk("c2_vld",  32'(fif.InstValid), 1);
    chk("c2_opc",  32'(fif.Opcode), 3'b011);
    cyc();                                  // cycle 3
    chk("c3_addr", 32'(fif.InstAddr), 7);
    chk("c3_vld",  32'(fif.InstValid), 1);
    cyc();                                  // cycle 4: br valid
    chk("c4_addr", 32'(fif.InstAddr), 8);
    chk("c4_ins",  32'(fif.Instruction), 32'(I_BR));
    chk("c4_vld",  32'(fif.InstValid), 1);
    cyc();                                  // cycle 5: bubble (addr 8 squashed)
    chk("br_tgt_addr", 32'(fif.InstAddr), 20);
    chk("br_bubble",   32'(fif.InstValid), 0);
    cyc();                                  // cycle 6
    chk("c6_addr", 32'(fif.InstAddr), 21);
    chk("c6_vld",  32'(fif.InstValid), 1);
    chk("c6_opc",  32'(fif.Opcode), 32'(OP_SUB));
    cyc();                                  // cycle 7: bez, Zero=0
    chk("c7_ins",  32'(fif.Instruction), 32'(I_BEZ));
    chk("c7_vld",  32'(fif.InstValid), 1);
    cyc();                                  // cycle 8: no bubble; bez, Zero=1
    chk("bez_nt_addr", 32'(fif.InstAddr), 23);
    chk("bez_nt_vld",  32'(fif.InstValid), 1);
    fif.Zero = 1'b1; fif.BranchTarget = 10'd40;
    cyc();                                  // cycle 9
    fif.Zero = 1'b0;
    chk("bez_t_addr", 32'(fif.InstAddr), 40);
    chk("bez_t_vld",  32'(fif.InstValid), 0);
    cyc();                                  // cycle 10
    chk("c10_addr", 32'(fif.InstAddr), 41);
    chk("c10_vld",  32'(fif.InstValid), 1);
    cyc();                                  // cycle 11: halt with Branch
    chk("c11_ins", 32'(fif.Instruction), 32'(I_HALT));
    force_br = 1'b1; fif.BranchTarget = 10'd60;
    cyc();                                  // cycle 12
    chk("halt_done", 32'(fif.Done), 1);
    chk("halt_vld",  32'(fif.InstValid), 0);
    chk("halt_addr", 32'(fif.InstAddr), 42);
    chk("halt_cnt",  32'(fif.CycleCount), 11);
    cyc();                                  // cycle 13: frozen
    force_br = 1'b0;
    chk("hold_addr", 32'(fif.InstAddr), 42);
    chk("hold_cnt",  32'(fif.CycleCount), 11);
    chk("hold_done", 32'(fif.Done), 1);

    // Restart from HALTED; Start held into RUN must be ignored
    fif.StartAddr = 10'd0; fif.Start = 1'b1;
    cyc();                                  // cycle 14
    chk("rs_addr", 32'(fif.InstAddr), 0);
    chk("rs_done", 32'(fif.Done), 0);
    chk("rs_cnt",  32'(fif.CycleCount), 0);
    chk("rs_vld",  32'(fif.InstValid), 0);
    cyc();                                  // cycle 15
    chk("run_start_ign", 32'(fif.InstAddr), 1);
    chk("rs2_vld",       32'(fif.InstValid), 1);
    chk("rs2_cnt",       32'(fif.CycleCount), 1);

    // Reset mid-run, with Start also high: reset wins
    rst_n = 1'b0; fif.StartAddr = 10'd1023;
    cyc();
    chk("mrst_addr", 32'(fif.InstAddr), 0);
    chk("mrst_vld",  32'(fif.InstValid), 0);
    chk("mrst_done", 32'(fif.Done), 0);
    chk("mrst_cnt",  32'(fif.CycleCount), 0);

    // Start at 1023, PC wrap
    rst_n = 1'b1;
    cyc();                                  // r1
    fif.Start = 1'b0;
    chk("wr_addr0", 32'(fif.InstAddr), 1023);
    cyc();                                  // r2
    chk("wr_addr1", 32'(fif.InstAddr), 0);
    chk("wr_vld",   32'(fif.InstValid), 1);
    chk("wr_cnt",   32'(fif.CycleCount), 1);

    // Counter saturation (CNT_W = 4)
    repeat (13) cyc();                      // r15
    chk("sat_14", 32'(fif.CycleCount), 14);
    cyc();                                  // r16
    chk("sat_15", 32'(fif.CycleCount), 15);
    repeat (10) cyc();                      // r26
    chk("sat_hold", 32'(fif.CycleCount), 15);
    chk("sat_done", 32'(fif.Done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
